// File: rtl/fphub_pkg.sv
// Shared FPHUB definitions: normalizer FSM states and field-width helpers.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package fphub_pkg;

  // Normalizer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } norm_state_t;

  // Default field widths of the single-precision HUB format.
  localparam int DEF_MAN_W = 24;
  localparam int DEF_EXP_W = 8;

  // Stored mantissa width; the explicit leading one sits at bit m-1.
  function automatic int man_w(input int m);
    return m;
  endfunction

  // Biased exponent field width.
  function automatic int exp_w(input int e);
    return e;
  endfunction

  // Packed result word: {sign, exponent, mantissa}.
  function automatic int word_w(input int m, input int e);
    return m + e + 1;
  endfunction

  // Raw adder sum: carry, mantissa and ILSB.
  function automatic int sum_w(input int m);
    return m + 2;
  endfunction

  // Largest encodable exponent for an e-bit field.
  function automatic int exp_max(input int e);
    return (1 << e) - 1;
  endfunction

  localparam int EXP_MAX = (1 << DEF_EXP_W) - 1;

endpackage

// File: rtl/fphub_pack.sv
// Assembles the packed HUB word and applies zero/underflow flush or overflow saturation.
// Latency: combinational, feeds the result register of the normalizer.
// Backpressure: none, pure function of its inputs.
module fphub_pack
  import fphub_pkg::*;
#(
  parameter int M = 24,
  parameter int E = 8
) (
  input  logic                      i_sign,
  input  logic [exp_w(E)-1:0]       i_exp,
  input  logic [man_w(M)-1:0]       i_man,
  input  logic                      i_zero,
  input  logic                      i_ovf,
  input  logic                      i_uf,
  output logic [word_w(M, E)-1:0]   o_word
);

  // Zero and underflow both produce +0; overflow keeps the sign and saturates every other bit.
  always_comb begin
    o_word = {i_sign, i_exp, i_man};
    if (i_zero || i_uf) begin
      o_word = '0;
    end else if (i_ovf) begin
      o_word = {i_sign, {E{1'b1}}, {M{1'b1}}};
    end
  end

endmodule

// File: rtl/fphub_normalizer.sv
// Normalizes the FPHUB adder sum one bit position per cycle and packs the HUB result.
// Latency: 2 cycles for carry/normalized/zero sums, 2+k for a k-position left shift (max 2+M).
// Backpressure: one operation in flight; in_ready stays low until out_valid is taken by out_ready.
module fphub_normalizer
  import fphub_pkg::*;
#(
  parameter int M = 24,
  parameter int E = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [M+1:0]   sum_in,
  input  logic           sign_in,
  input  logic [E-1:0]   exp_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [E+M:0]   result,
  output logic           zero_flag,
  output logic           ovf_flag,
  output logic           uf_flag
);

  localparam int SW = sum_w(M);
  localparam int WW = word_w(M, E);
  localparam int XMAX_I = exp_max(E);
  // Working exponent is one bit wider so the carry increment cannot wrap.
  localparam logic [E:0] XMAX  = XMAX_I[E:0];
  localparam logic [E:0] X_ONE = {{E{1'b0}}, 1'b1};

  norm_state_t     r_state;
  logic [SW-1:0]   r_w;
  logic            r_sign;
  logic [E:0]      r_x;
  logic            r_out_valid;
  logic [WW-1:0]   r_result;
  logic            r_zero;
  logic            r_ovf;
  logic            r_uf;

  logic [E:0]      w_x_inc;
  logic [E:0]      w_x_dec;
  logic            w_term;
  logic            w_zero;
  logic            w_ovf;
  logic            w_uf;
  logic [M-1:0]    w_man;
  logic [E-1:0]    w_exp;
  logic [WW-1:0]   w_word;

  assign in_ready  = (r_state == IDLE) && !rst;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero_flag = r_zero;
  assign ovf_flag  = r_ovf;
  assign uf_flag   = r_uf;

  assign w_x_inc = r_x + X_ONE;
  assign w_x_dec = r_x - X_ONE;

  // One normalization step: decide whether this cycle finishes the operation and with which fields.
  always_comb begin
    w_term = 1'b0;
    w_zero = 1'b0;
    w_ovf  = 1'b0;
    w_uf   = 1'b0;
    w_man  = r_w[M:1];
    w_exp  = r_x[E-1:0];
    if (r_w == '0) begin
      // Exact cancellation: no leading one will ever appear.
      w_term = 1'b1;
      w_zero = 1'b1;
    end else if (r_w[M+1]) begin
      // Carry out: drop one position right; the dropped bit is discarded (HUB truncation).
      w_term = 1'b1;
      w_man  = r_w[M+1:2];
      w_exp  = w_x_inc[E-1:0];
      w_ovf  = (w_x_inc > XMAX);
    end else if (r_w[M]) begin
      // Leading one already in place.
      w_term = 1'b1;
    end else if ((r_x == '0) || (w_x_dec == '0)) begin
      // A shift would reach the reserved exponent 0 (or the input already had it): flush.
      w_term = 1'b1;
      w_uf   = 1'b1;
    end
  end

  fphub_pack #(
    .M (M),
    .E (E)
  ) u_pack (
    .i_sign (r_sign),
    .i_exp  (w_exp),
    .i_man  (w_man),
    .i_zero (w_zero),
    .i_ovf  (w_ovf),
    .i_uf   (w_uf),
    .o_word (w_word)
  );

  // Control FSM with registered result, flags and output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_w         <= '0;
      r_sign      <= 1'b0;
      r_x         <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_uf        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_w     <= sum_in;
            r_sign  <= sign_in;
            r_x     <= {1'b0, exp_in};
            r_state <= NORM;
          end
        end
        NORM: begin
          if (w_term) begin
            r_result <= w_word;
            r_zero   <= w_zero;
            r_ovf    <= w_ovf;
            r_uf     <= w_uf;
            r_state  <= DONE;
          end else begin
            r_w <= {r_w[SW-2:0], 1'b0};
            r_x <= w_x_dec;
          end
        end
        DONE: begin
          // Result lands one cycle before out_valid rises; flags clear together with out_valid.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
            r_uf        <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fphub_normalizer.sv
// Scoreboard bench for fphub_normalizer: expectations queued at accept, checked at first out_valid.
// Latency is measured from the accept edge to the first cycle out_valid is seen.
// Backpressure is exercised both with a fixed stall and with random out_ready.
module tb_fphub_normalizer;

  localparam int M = 24;
  localparam int E = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [M+1:0]   sum_in;
  logic           sign_in;
  logic [E-1:0]   exp_in;
  logic           out_valid;
  logic           out_ready;
  logic [E+M:0]   result;
  logic           zero_flag;
  logic           ovf_flag;
  logic           uf_flag;

  typedef struct {
    logic [E+M:0] res;
    logic         z;
    logic         o;
    logic         u;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_miss = 0;
  int   cyc = 0;
  bit   mon_seen = 0;
  bit   bp_on = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  fphub_normalizer #(.M(M), .E(E)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_in    (sum_in),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero_flag (zero_flag),
    .ovf_flag  (ovf_flag),
    .uf_flag   (uf_flag)
  );

  // Scoreboard: pop one expectation on the first cycle of each out_valid pulse.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rst || !out_valid) begin
        mon_seen = 0;
      end else if (!mon_seen) begin
        mon_seen = 1;
        n_vec++;
        if (sb.size() == 0) begin
          n_miss++;
          $display("FAIL unexpected_output result=%h", result);
        end else begin
          mon_e = sb.pop_front();
          if (result !== mon_e.res) begin
            n_miss++;
            $display("FAIL result got=%h want=%h", result, mon_e.res);
          end
          n_vec++;
          if ({zero_flag, ovf_flag, uf_flag} !== {mon_e.z, mon_e.o, mon_e.u}) begin
            n_miss++;
            $display("FAIL flags(z,o,u) got=%b want=%b", {zero_flag, ovf_flag, uf_flag},
                     {mon_e.z, mon_e.o, mon_e.u});
          end
          n_vec++;
          if (cyc - mon_e.acc != mon_e.lat) begin
            n_miss++;
            $display("FAIL latency got=%0d want=%0d", cyc - mon_e.acc, mon_e.lat);
          end
        end
      end
    end
  end

  // Random downstream stalls while enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_on) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Reference behaviour of the normalizer for one operand set.
  function automatic exp_t model(input logic [M+1:0] s, input logic sg, input logic [E-1:0] e);
    exp_t         r;
    int           p;
    int           k;
    logic [M+1:0] sh;
    logic [E-1:0] ne;
    r.res = '0; r.z = 0; r.o = 0; r.u = 0; r.lat = 2; r.acc = 0;
    if (s == '0) begin
      r.z = 1;
    end else if (s[M+1]) begin
      if (e == 8'hFF) begin
        r.o = 1;
        r.res = {sg, {E{1'b1}}, {M{1'b1}}};
      end else begin
        r.res = {sg, e + 8'd1, s[M+1:2]};
      end
    end else if (s[M]) begin
      r.res = {sg, e, s[M:1]};
    end else begin
      p = -1;
      for (int i = M - 1; i >= 0; i--) if (s[i] && p < 0) p = i;
      k = M - p;
      if (int'(e) <= k) begin
        r.u = 1;
        r.lat = ((e == 0) ? 1 : int'(e)) + 1;
      end else begin
        sh = s << k;
        ne = e - k[E-1:0];
        r.res = {sg, ne, sh[M:1]};
        r.lat = 2 + k;
      end
    end
    return r;
  endfunction

  // Present one operand set, wait for acceptance, then queue its expectation.
  task automatic send(input logic [M+1:0] s, input logic sg, input logic [E-1:0] e,
                      input logic [E+M:0] xres, input logic xz, input logic xo, input logic xu,
                      input int xlat);
    exp_t ent;
    bit   took;
    took = 0;
    sum_in = s; sign_in = sg; exp_in = e; in_valid = 1'b1;
    for (int i = 0; i < 300 && !took; i++) begin
      if (in_ready) took = 1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!took) begin
      n_vec++; n_miss++;
      $display("FAIL accept_timeout in_ready=%b want=1", in_ready);
    end else begin
      ent.res = xres; ent.z = xz; ent.o = xo; ent.u = xu; ent.lat = xlat; ent.acc = cyc;
      sb.push_back(ent);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && (sb.size() != 0 || out_valid); i++) begin
      @(posedge clk);
      #1;
    end
    if (sb.size() != 0 || out_valid) begin
      n_vec++; n_miss++;
      $display("FAIL drain_timeout pending=%0d want=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    sum_in = '0; sign_in = 1'b0; exp_in = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin n_miss++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    n_vec++;
    if (result !== '0) begin n_miss++; $display("FAIL rst_result got=%h want=0", result); end
    n_vec++;
    if ({zero_flag, ovf_flag, uf_flag} !== 3'b000) begin
      n_miss++; $display("FAIL rst_flags got=%b want=000", {zero_flag, ovf_flag, uf_flag});
    end
    n_vec++;
    if (in_ready !== 1'b0) begin n_miss++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
    rst = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_miss++; $display("FAIL idle_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_basic();
    send(26'h1000001, 1'b0, 8'h80, {1'b0, 8'h80, 24'h800000}, 0, 0, 0, 2);
    wait_done();
    send(26'h2000001, 1'b1, 8'h80, {1'b1, 8'h81, 24'h800000}, 0, 0, 0, 2);
    wait_done();
    send(26'h0200001, 1'b0, 8'h80, {1'b0, 8'h7D, 24'h800004}, 0, 0, 0, 5);
    wait_done();
    send(26'h0000001, 1'b0, 8'h80, {1'b0, 8'h68, 24'h800000}, 0, 0, 0, 2 + M);
    wait_done();
  endtask

  task automatic test_flags();
    send(26'h0000000, 1'b1, 8'h55, '0, 1, 0, 0, 2);
    wait_done();
    send(26'h2000001, 1'b1, 8'hFF, {1'b1, 8'hFF, 24'hFFFFFF}, 0, 1, 0, 2);
    wait_done();
    send(26'h0000801, 1'b1, 8'h02, '0, 0, 0, 1, 3);
    wait_done();
    send(26'h1000001, 1'b1, 8'h00, {1'b1, 8'h00, 24'h800000}, 0, 0, 0, 2);
    wait_done();
    send(26'h0400000, 1'b0, 8'h00, '0, 0, 0, 1, 2);
    wait_done();
  endtask

  task automatic test_backpressure();
    int waited;
    out_ready = 1'b0;
    send(26'h1800003, 1'b1, 8'h40, {1'b1, 8'h40, 24'hC00001}, 0, 0, 0, 2);
    waited = 0;
    while (!out_valid && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    n_vec++;
    if (out_valid !== 1'b1) begin n_miss++; $display("FAIL bp_out_valid_timeout got=%b want=1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; sum_in = 26'h2000001; sign_in = 1'b0; exp_in = 8'h10;
      @(posedge clk);
      #1;
      n_vec++;
      if (out_valid !== 1'b1) begin n_miss++; $display("FAIL bp_hold_valid got=%b want=1", out_valid); end
      n_vec++;
      if (result !== {1'b1, 8'h40, 24'hC00001}) begin
        n_miss++; $display("FAIL bp_hold_result got=%h want=%h", result, {1'b1, 8'h40, 24'hC00001});
      end
      n_vec++;
      if ({zero_flag, ovf_flag, uf_flag} !== 3'b000) begin
        n_miss++; $display("FAIL bp_hold_flags got=%b want=000", {zero_flag, ovf_flag, uf_flag});
      end
      n_vec++;
      if (in_ready !== 1'b0) begin n_miss++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin n_miss++; $display("FAIL bp_release_valid got=%b want=0", out_valid); end
    n_vec++;
    if (in_ready !== 1'b1) begin n_miss++; $display("FAIL bp_release_in_ready got=%b want=1", in_ready); end
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    n_vec++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      n_miss++; $display("FAIL bp_phantom_op out_valid=%b pending=%0d want 0/0", out_valid, sb.size());
    end
  endtask

  task automatic test_reset_mid_norm();
    bit saw;
    send(26'h0200001, 1'b0, 8'h80, {1'b0, 8'h7D, 24'h800004}, 0, 0, 0, 5);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    n_vec++;
    if (out_valid !== 1'b0) begin n_miss++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
    n_vec++;
    if (result !== '0) begin n_miss++; $display("FAIL midrst_result got=%h want=0", result); end
    rst = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_miss++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
    saw = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) saw = 1;
    end
    n_vec++;
    if (saw) begin n_miss++; $display("FAIL midrst_discard out_valid seen=1 want=0"); end
    send(26'h1000001, 1'b0, 8'h80, {1'b0, 8'h80, 24'h800000}, 0, 0, 0, 2);
    wait_done();
  endtask

  task automatic test_back_to_back();
    exp_t         m;
    logic [M+1:0] s;
    logic [E-1:0] e;
    logic         sg;
    int           p;
    bp_on = 1;
    for (int n = 0; n < 40; n++) begin
      p = $urandom_range(0, M + 2);
      s = 26'($urandom) & 26'h3FFFFFF;
      if (p == M + 2) s = '0;
      else s = (s & ((26'd1 << p) - 26'd1)) | (26'd1 << p);
      e = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 255));
      if (n % 10 == 9) e = 8'hFF;
      sg = 1'($urandom_range(0, 1));
      m = model(s, sg, e);
      send(s, sg, e, m.res, m.z, m.o, m.u, m.lat);
    end
    bp_on = 0;
    out_ready = 1'b1;
    wait_done();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flags();
    test_backpressure();
    test_reset_mid_norm();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
